// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with register-file write-through forwarding,
// load-use hazard detection, flush handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [15:0]   id_imm16,
  input  logic [CW-1:0] id_ctrl,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [4:0]    wb_wr,
  input  logic [DW-1:0] wb_wd,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_dst,
  output logic [CW-1:0] ex_ctrl,
  output logic          stall,
  output logic [15:0]   bubble_cnt
);

  // Bit positions inside the MSB-first control bundle.
  localparam int MEMREAD = CW - 2;
  localparam int REGDST  = CW - 5;

  logic          hz;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // A load in EX whose destination is a source of the ID instruction.
  always_comb begin
    hz = id_valid & ex_valid & ex_ctrl[MEMREAD] & (ex_rt != 5'd0) &
         ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

  assign stall = hz & ~flush;

  // The register file is written on the same edge, so take the WB value directly.
  always_comb begin
    fwd_a = id_rd1;
    if (id_rs == 5'd0)
      fwd_a = '0;
    else if (wb_we && (wb_wr == id_rs))
      fwd_a = wb_wd;

    fwd_b = id_rd2;
    if (id_rt == 5'd0)
      fwd_b = '0;
    else if (wb_we && (wb_wr == id_rt))
      fwd_b = wb_wd;
  end

  // Data fields always load; only valid/ctrl are squashed to form a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_dst   <= 5'd0;
    end else begin
      ex_a   <= fwd_a;
      ex_b   <= fwd_b;
      ex_imm <= {{(DW-16){id_imm16[15]}}, id_imm16};
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_dst <= id_ctrl[REGDST] ? id_rd : id_rt;
      if (flush || hz) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
      end
    end
  end

  // Only stall-induced bubbles are counted; flush bubbles are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= 16'd0;
    else if (stall && (bubble_cnt != 16'hFFFF))
      bubble_cnt <= bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table driven through a scoreboard queue,
// plus hand-written saturation and asynchronous-reset sequences.
module tb_id_ex_stage;

  localparam logic [8:0] C_LW  = 9'h1A8;
  localparam logic [8:0] C_R   = 9'h112;
  localparam logic [8:0] C_IMM = 9'h108;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rd1, id_rd2;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [8:0]  id_ctrl;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [8:0]  ex_ctrl;
  logic        stall;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        valid;
    logic [8:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2;
    logic [15:0] imm;
    logic        flush;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        e_stall;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [31:0] e_a, e_b, e_imm;
    logic [4:0]  e_dst;
    logic [15:0] e_bcnt;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, dst;
    logic [15:0] bcnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  id_ex_stage #(.DW(32), .CW(9)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm16(id_imm16), .id_ctrl(id_ctrl), .flush(flush),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_ctrl(ex_ctrl),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string name, logic valid, logic [8:0] ctrl,
      logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
      logic [31:0] rd1, logic [31:0] rd2, logic [15:0] imm, logic fl,
      logic we, logic [4:0] wr, logic [31:0] wd,
      logic e_stall, logic e_valid, logic [8:0] e_ctrl,
      logic [31:0] e_a, logic [31:0] e_b, logic [31:0] e_imm,
      logic [4:0] e_dst, logic [15:0] e_bcnt);
    vec_t v;
    v.name = name; v.valid = valid; v.ctrl = ctrl;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.flush = fl; v.we = we; v.wr = wr; v.wd = wd;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_ctrl = e_ctrl;
    v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm; v.e_dst = e_dst;
    v.e_bcnt = e_bcnt;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    id_valid = v.valid; id_ctrl = v.ctrl;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm16 = v.imm;
    flush = v.flush; wb_we = v.we; wb_wr = v.wr; wb_wd = v.wd;
  endtask

  // Drive at negedge, check stall combinationally, compare EX after the edge.
  task automatic stepVec(vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({v.name, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    e.name = v.name; e.valid = v.e_valid; e.ctrl = v.e_ctrl;
    e.a = v.e_a; e.b = v.e_b; e.imm = v.e_imm;
    e.rs = v.rs; e.rt = v.rt; e.dst = v.e_dst; e.bcnt = v.e_bcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({got.name, ".valid"}, {31'd0, ex_valid}, {31'd0, got.valid});
    checkOutput({got.name, ".ctrl"}, {23'd0, ex_ctrl}, {23'd0, got.ctrl});
    checkOutput({got.name, ".a"}, ex_a, got.a);
    checkOutput({got.name, ".b"}, ex_b, got.b);
    checkOutput({got.name, ".imm"}, ex_imm, got.imm);
    checkOutput({got.name, ".rs"}, {27'd0, ex_rs}, {27'd0, got.rs});
    checkOutput({got.name, ".rt"}, {27'd0, ex_rt}, {27'd0, got.rt});
    checkOutput({got.name, ".dst"}, {27'd0, ex_dst}, {27'd0, got.dst});
    checkOutput({got.name, ".bcnt"}, {16'd0, bubble_cnt}, {16'd0, got.bcnt});
  endtask

  task automatic checkAllZero(string name);
    checkOutput({name, ".valid"}, {31'd0, ex_valid}, 32'd0);
    checkOutput({name, ".ctrl"}, {23'd0, ex_ctrl}, 32'd0);
    checkOutput({name, ".a"}, ex_a, 32'd0);
    checkOutput({name, ".b"}, ex_b, 32'd0);
    checkOutput({name, ".imm"}, ex_imm, 32'd0);
    checkOutput({name, ".dst"}, {27'd0, ex_dst}, 32'd0);
    checkOutput({name, ".rt"}, {27'd0, ex_rt}, 32'd0);
    checkOutput({name, ".bcnt"}, {16'd0, bubble_cnt}, 32'd0);
    checkOutput({name, ".stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    // name valid ctrl rs rt rd rd1 rd2 imm flush we wr wd | stall valid ctrl a b imm dst bcnt
    vecs.push_back(mk("fwd_a", 1, C_R, 8, 2, 3, 32'h0, 32'h22, 16'h0, 0, 1, 8, 32'h1234_5678,
                      0, 1, C_R, 32'h1234_5678, 32'h22, 32'h0, 3, 0));
    vecs.push_back(mk("rs_zero", 1, C_IMM, 0, 8, 7, 32'hDEAD, 32'h5, 16'h8001, 0, 1, 8, 32'h1234_5678,
                      0, 1, C_IMM, 32'h0, 32'h1234_5678, 32'hFFFF_8001, 8, 0));
    vecs.push_back(mk("imm_rd", 1, C_R, 5, 4, 3, 32'h55, 32'h44, 16'h8001, 0, 0, 0, 32'h0,
                      0, 1, C_R, 32'h55, 32'h44, 32'hFFFF_8001, 3, 0));
    vecs.push_back(mk("lw9", 1, C_LW, 1, 9, 0, 32'h100, 32'h99, 16'h0004, 0, 0, 0, 32'h0,
                      0, 1, C_LW, 32'h100, 32'h99, 32'h4, 9, 0));
    vecs.push_back(mk("use_rs", 1, C_R, 9, 2, 10, 32'h11, 32'h22, 16'h0, 0, 1, 9, 32'hAAAA,
                      1, 0, 9'h0, 32'hAAAA, 32'h22, 32'h0, 10, 1));
    vecs.push_back(mk("replay", 1, C_R, 9, 2, 10, 32'h11, 32'h22, 16'h0, 0, 1, 9, 32'hAAAA,
                      0, 1, C_R, 32'hAAAA, 32'h22, 32'h0, 10, 1));
    vecs.push_back(mk("invalid", 0, C_LW, 3, 4, 5, 32'h1, 32'h2, 16'hFFFF, 0, 0, 0, 32'h0,
                      0, 0, 9'h0, 32'h1, 32'h2, 32'hFFFF_FFFF, 4, 1));
    vecs.push_back(mk("lw12", 1, C_LW, 2, 12, 0, 32'h2, 32'hC, 16'h0010, 0, 0, 0, 32'h0,
                      0, 1, C_LW, 32'h2, 32'hC, 32'h10, 12, 1));
    vecs.push_back(mk("flush_hz", 1, C_R, 0, 12, 13, 32'h7, 32'h8, 16'h0, 1, 0, 0, 32'h0,
                      0, 0, 9'h0, 32'h0, 32'h8, 32'h0, 13, 1));
    vecs.push_back(mk("lw0", 1, C_LW, 3, 0, 0, 32'h3, 32'h77, 16'h0, 0, 0, 0, 32'h0,
                      0, 1, C_LW, 32'h3, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk("rt0_nohz", 1, C_R, 0, 0, 6, 32'h5, 32'h6, 16'h0, 0, 0, 0, 32'h0,
                      0, 1, C_R, 32'h0, 32'h0, 32'h0, 6, 1));
    vecs.push_back(mk("lw17", 1, C_LW, 1, 17, 0, 32'h10, 32'h17, 16'h0, 0, 0, 0, 32'h0,
                      0, 1, C_LW, 32'h10, 32'h17, 32'h0, 17, 1));
    vecs.push_back(mk("use_rt", 1, C_R, 4, 17, 18, 32'h4, 32'h1717, 16'h0, 0, 0, 0, 32'h0,
                      1, 0, 9'h0, 32'h4, 32'h1717, 32'h0, 18, 2));

    // Reset state, with inputs shaped like a hazard.
    rst = 1'b1;
    applyStimulus(vecs[4]);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) stepVec(vecs[i]);

    // Saturation: jump the counter near its limit, then two more hazards.
    stepVec(mk("sat_lw1", 1, C_LW, 1, 9, 0, 32'h1, 32'h2, 16'h0, 0, 0, 0, 32'h0,
               0, 1, C_LW, 32'h1, 32'h2, 32'h0, 9, 2));
    force dut.bubble_cnt = 16'hFFFE;
    #1;
    release dut.bubble_cnt;
    stepVec(mk("sat_hz1", 1, C_R, 9, 3, 4, 32'h9, 32'h3, 16'h0, 0, 0, 0, 32'h0,
               1, 0, 9'h0, 32'h9, 32'h3, 32'h0, 4, 16'hFFFF));
    stepVec(mk("sat_lw2", 1, C_LW, 1, 9, 0, 32'h1, 32'h2, 16'h0, 0, 0, 0, 32'h0,
               0, 1, C_LW, 32'h1, 32'h2, 32'h0, 9, 16'hFFFF));
    stepVec(mk("sat_hz2", 1, C_R, 9, 3, 4, 32'h9, 32'h3, 16'h0, 0, 0, 0, 32'h0,
               1, 0, 9'h0, 32'h9, 32'h3, 32'h0, 4, 16'hFFFF));

    // Asynchronous reset in the middle of a stalled cycle.
    stepVec(mk("ar_lw", 1, C_LW, 1, 9, 0, 32'h1, 32'h2, 16'h0, 0, 0, 0, 32'h0,
               0, 1, C_LW, 32'h1, 32'h2, 32'h0, 9, 16'hFFFF));
    @(negedge clk);
    applyStimulus(mk("ar_hz", 1, C_R, 9, 3, 4, 32'h9, 32'h3, 16'h0, 0, 0, 0, 32'h0,
                     0, 0, 9'h0, 32'h0, 32'h0, 32'h0, 0, 0));
    #1;
    checkOutput("ar_pre.stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    #1;
    rst = 1'b0;
    stepVec(mk("post_rst", 1, C_R, 5, 6, 7, 32'h50, 32'h60, 16'h0002, 0, 0, 0, 32'h0,
               0, 1, C_R, 32'h50, 32'h60, 32'h2, 7, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, operand/immediate output width (only 32 supported).
REQ-002 SHALL have parameter CW, default 9, control bundle width {RegWrite,MemRead,MemWrite,MemtoReg,RegDst,ALUSrc,Branch,ALUOp[1:0]}, MSB first.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rd1, id_rd2  in  32  register-file read data for rs and rt.
REQ-007 id_rs, id_rt, id_rd  in  5  instruction register fields.
REQ-008 id_imm16  in  16  instruction immediate.
REQ-009 id_ctrl  in  CW  decoded control bundle.
REQ-010 flush  in  1  discard the ID instruction (taken branch/jump).
REQ-011 wb_we, wb_wr, wb_wd  in  1/5/32  write port currently driven into the register file.
REQ-012 ex_valid  out  1; ex_a, ex_b  out  32; ex_imm  out  32; ex_rs, ex_rt, ex_dst  out  5; ex_ctrl  out  CW.
REQ-013 stall  out  1  combinational; holds PC and IF/ID when high.
REQ-014 bubble_cnt  out  16  count of bubbles inserted.

Function
REQ-015 Load-use hazard SHALL be hz = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-016 stall SHALL equal hz & ~flush, with zero clock latency.
REQ-017 Each edge, if flush or hz: ex_valid<=0, ex_ctrl<=0; ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dst SHALL still load from the ID inputs.
REQ-018 Each edge otherwise: ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0; all data fields load as per REQ-019..REQ-022.
REQ-019 ex_a SHALL load 0 if id_rs==0; else wb_wd if wb_we & wb_wr==id_rs; else id_rd1.
REQ-020 ex_b SHALL follow the same rule using id_rt and id_rd2.
REQ-021 ex_imm SHALL load {16{id_imm16[15]}, id_imm16}.
REQ-022 ex_dst SHALL load id_rd when id_ctrl.RegDst=1, else id_rt; ex_rs/ex_rt load id_rs/id_rt.
REQ-023 bubble_cnt SHALL increment by 1 on each edge where hz & ~flush, saturate at 16'hFFFF, and never wrap.
REQ-024 Flush SHALL take priority over stall; flush and hz in the same cycle inserts one bubble, stall=0, and bubble_cnt does not increment.
REQ-025 A stalled instruction re-presented next cycle SHALL see hz=0, because the bubble cleared ex_ctrl.MemRead, so it advances normally.
REQ-026 Pipeline latency SHALL be exactly one cycle from ID inputs to ex_* outputs; there are no other storage stages.
REQ-027 Inputs with id_valid=0 SHALL produce ex_valid=0 and ex_ctrl=0 regardless of id_ctrl.

Reset
REQ-028 While rst=1, all ex_* outputs and bubble_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 stall SHALL be 0 while rst=1, since ex_valid=0.
REQ-030 On rst deassertion the first rising edge SHALL capture ID inputs normally.
REQ-031 rst mid-stall SHALL drop stall asynchronously and discard the in-flight EX contents.

Verification
REQ-032 Forwarding: wb_we=1, wb_wr=8, wb_wd=32'h1234_5678, id_rs=8, id_rd1=32'h0 -> ex_a=32'h1234_5678 after the edge; id_rs=0 with the same WB -> ex_a=0.
REQ-033 Load-use: EX holds lw with ex_rt=9; ID has id_rt=9, id_valid=1 -> stall=1 that cycle; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle stall=0, instruction enters EX.
REQ-034 Flush+hazard: conditions of REQ-033 plus flush=1 -> stall=0, next edge ex_valid=0, bubble_cnt unchanged.
REQ-035 Immediate/dest: id_imm16=16'h8001, RegDst=1, id_rd=5'd3, id_rt=5'd4 -> ex_imm=32'hFFFF_8001, ex_dst=3; RegDst=0 -> ex_dst=4.
REQ-036 Saturation: preload bubble_cnt to 16'hFFFE via 2 further hazards -> 16'hFFFF, then stays at 16'hFFFF.
REQ-037 Async reset: assert rst between edges while ex_valid=1 -> all outputs 0 before the next edge, and stall=0.
